reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between decoder/CDB and the register file.
- Allocates a ROB tag per decoded instruction and captures results broadcast on the CDB.
- Retires at most one ready head entry per cycle, driving the register file's commit triple: reg index, entry tag and value.
- Tag 0 (`ZERO_ROB`) is reserved as "no producer"; live tags are 1..ROB_SIZE-1.

Parameters:
ROB_SIZE, 16, number of tag slots including reserved tag 0; usable entries = ROB_SIZE-1; must equal 2^`ROB_WIDTH` width.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
ena  in  1  global enable; low = hold all state
in_alloc_ena  in  1  decoder requests an entry this cycle
in_alloc_rd  in  `REG_WIDTH  destination reg of the allocating instruction (0 = none)
out_alloc_tag  out  `ROB_WIDTH  tag granted if allocated this cycle (combinational = tail)
out_full  out  1  no free entry (combinational)
in_cdb_ena  in  1  CDB broadcast valid
in_cdb_tag  in  `ROB_WIDTH  producing tag
in_cdb_value  in  `DATA_WIDTH  result
in_query_tag1  in  `ROB_WIDTH  decoder operand-1 producer tag
in_query_tag2  in  `ROB_WIDTH  decoder operand-2 producer tag
out_query_ready1  out  1  entry for tag1 holds its value (combinational)
out_query_ready2  out  1  entry for tag2 holds its value (combinational)
out_query_value1  out  `DATA_WIDTH  value for tag1
out_query_value2  out  `DATA_WIDTH  value for tag2
out_commit_reg  out  `REG_WIDTH  retiring destination reg; 0 = no commit
out_commit_tag  out  `ROB_WIDTH  retiring tag
out_commit_value  out  `DATA_WIDTH  retiring value

Behaviour:
- Per-entry state: valid, ready, rd, value. Pointers head and tail range 1..ROB_SIZE-1. count ranges 0..ROB_SIZE-1.
- Reset:
  - head = tail = 1; count = 0; all valid/ready = 0.
  - out_commit_reg/tag/value = 0.
  - out_full = 0; out_alloc_tag = 1.
- Pointer advance: increment then wrap ROB_SIZE-1 -> 1. Tag 0 is never issued.
- out_full = (count == ROB_SIZE-1). out_alloc_tag = tail at all times.
- Allocate:
  - Condition: ena && in_alloc_ena && !out_full.
  - Action at edge: entry[tail] gets valid=1, ready=0, rd=in_alloc_rd; tail advances.
  - An allocate while out_full is dropped; the decoder must stall.
- Writeback:
  - Condition: ena && in_cdb_ena && entry[in_cdb_tag].valid.
  - Action at edge: value written, ready=1.
  - Tag 0 or an invalid entry is ignored.
- Commit:
  - Condition: ena && entry[head].valid && entry[head].ready.
  - Action at edge: out_commit_reg/tag/value are registered from the head entry; entry[head].valid cleared; head advances.
  - Otherwise out_commit_reg = 0 and tag/value = 0.
  - Registered commit outputs are valid for exactly one cycle.
  - Latency: CDB write in cycle N -> earliest commit outputs visible after edge N+1.
- Count update: count += alloc - commit in the same edge.
  - Full plus commit in the same cycle: out_full is evaluated on the pre-edge count, so the allocate is still rejected.
- Entry reuse: allocate into the slot just vacated by commit is legal only from the next cycle; tail never equals head while count > 0 and not full.
- Query:
  - ready = entry[tag].valid && entry[tag].ready; value = entry[tag].value.
  - Tag 0 returns ready=0, value=0.
- ena low: no state change; out_commit_reg forced to 0 at the edge, so nothing retires twice.
- rst mid-operation discards all in-flight entries; the same-cycle alloc/CDB inputs are ignored.

Optional Feature:
ROB_CDB_BYPASS_EN
- Defined: a query whose tag equals in_cdb_tag while in_cdb_ena=1 and the entry is valid returns ready=1 with value=in_cdb_value in the same cycle. This saves one decode cycle.
- Undefined: queries reflect stored entry state only; the CDB value becomes visible the cycle after the broadcast.

Test Plan:
- Reset, then idle 3 cycles -> out_alloc_tag=1, out_full=0, out_commit_reg=0 every cycle.
- Alloc rd=5 (tag 1); CDB tag1 value 0xDEADBEEF next cycle -> following edge: out_commit_reg=5, out_commit_tag=1, out_commit_value=0xDEADBEEF for one cycle, then reg=0.
- Out-of-order completion: alloc rd=3 (tag 1) and rd=4 (tag 2); CDB tag2=7 before tag1=9 -> no commit until tag1 arrives; commits reg3=9 then reg4=7 on consecutive cycles.
- Fill 15 allocs with no CDB -> out_full=1 after the 15th. 16th alloc is ignored and tail stays 1. Completing tag1 -> commit, out_full drops, next alloc gets tag 1 (wrap, never 0).
- Query: tag 6 allocated, no result -> ready=0. With CDB tag 6=0x55 in the same cycle: with ROB_CDB_BYPASS_EN ready=1/value=0x55; without it, ready=0 that cycle and 1 the next.
- Hold and reset: ena=0 with a ready head for 2 cycles -> no commit, state held; ena=1 -> single commit. rst asserted with 4 live entries -> count 0, out_alloc_tag=1, no commits follow.

Source files
------------

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order reorder buffer that sits between the decoder/CDB and the
//   register file. Each decoded instruction gets a ROB tag. Results broadcast
//   on the CDB are captured into their entries. At most one ready head entry
//   retires per cycle, and the retirement drives the register file's commit
//   triple (reg, tag, value). Tag 0 (ZERO_ROB) means "no producer", so live
//   tags are 1..ROB_SIZE-1.
//
// Optional feature macro: ROB_CDB_BYPASS_EN
//   When defined, an operand query that matches the tag on the CDB in the
//   current cycle returns that broadcast value at once. The query does not
//   wait for the value to reach the entry.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ena                 global enable (low = hold all state, no commit)
//   in_alloc_ena/rd     decoder allocation request and its destination reg
//   out_alloc_tag       tag granted to an allocation this cycle (= tail)
//   out_full            no free entry
//   in_cdb_ena/tag/value  result broadcast
//   in_query_tag1/2     operand producer tags from the decoder
//   out_query_ready1/2, out_query_value1/2  operand availability and value
//   out_commit_reg/tag/value  registered retirement triple (reg 0 = none)
// -----------------------------------------------------------------------------
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reorder_buffer #(
    parameter int ROB_SIZE = 16  // must equal 2**`ROB_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   in_alloc_ena,
    input  logic [`REG_WIDTH-1:0]  in_alloc_rd,
    output logic [`ROB_WIDTH-1:0]  out_alloc_tag,
    output logic                   out_full,
    input  logic                   in_cdb_ena,
    input  logic [`ROB_WIDTH-1:0]  in_cdb_tag,
    input  logic [`DATA_WIDTH-1:0] in_cdb_value,
    input  logic [`ROB_WIDTH-1:0]  in_query_tag1,
    input  logic [`ROB_WIDTH-1:0]  in_query_tag2,
    output logic                   out_query_ready1,
    output logic                   out_query_ready2,
    output logic [`DATA_WIDTH-1:0] out_query_value1,
    output logic [`DATA_WIDTH-1:0] out_query_value2,
    output logic [`REG_WIDTH-1:0]  out_commit_reg,
    output logic [`ROB_WIDTH-1:0]  out_commit_tag,
    output logic [`DATA_WIDTH-1:0] out_commit_value
);

    localparam logic [`ROB_WIDTH-1:0] ZERO_ROB  = '0;
    localparam logic [`ROB_WIDTH-1:0] FIRST_TAG = `ROB_WIDTH'(1);
    localparam logic [`ROB_WIDTH-1:0] LAST_TAG  = `ROB_WIDTH'(ROB_SIZE - 1);

    // Per-entry state
    logic [ROB_SIZE-1:0]    valid_q;
    logic [ROB_SIZE-1:0]    ready_q;
    logic [`REG_WIDTH-1:0]  rd_q    [ROB_SIZE];
    logic [`DATA_WIDTH-1:0] value_q [ROB_SIZE];

    logic [`ROB_WIDTH-1:0] head_q, head_d;
    logic [`ROB_WIDTH-1:0] tail_q, tail_d;
    logic [`ROB_WIDTH-1:0] count_q, count_d;

    logic [`REG_WIDTH-1:0]  commit_reg_q;
    logic [`ROB_WIDTH-1:0]  commit_tag_q;
    logic [`DATA_WIDTH-1:0] commit_value_q;

    logic do_alloc;
    logic do_wb;
    logic do_commit;

    // Pointers skip the reserved tag 0 when they wrap.
    function automatic logic [`ROB_WIDTH-1:0] next_ptr(input logic [`ROB_WIDTH-1:0] p);
        return (p == LAST_TAG) ? FIRST_TAG : p + FIRST_TAG;
    endfunction

    assign out_full         = (count_q == LAST_TAG);
    assign out_alloc_tag    = tail_q;
    assign out_commit_reg   = commit_reg_q;
    assign out_commit_tag   = commit_tag_q;
    assign out_commit_value = commit_value_q;

    // Every decision uses pre-edge state. An allocation while full is
    // rejected even if the head retires in the same cycle.
    always_comb begin
        do_alloc  = ena && in_alloc_ena && !out_full;
        do_wb     = ena && in_cdb_ena && valid_q[in_cdb_tag];  // tag 0 is never valid
        do_commit = ena && valid_q[head_q] && ready_q[head_q];

        head_d = do_commit ? next_ptr(head_q) : head_q;
        tail_d = do_alloc  ? next_ptr(tail_q) : tail_q;

        count_d = count_q;
        case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + FIRST_TAG;
            2'b01:   count_d = count_q - FIRST_TAG;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every
    // decision above sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= FIRST_TAG;
            tail_q         <= FIRST_TAG;
            count_q        <= '0;
            valid_q        <= '0;
            ready_q        <= '0;
            commit_reg_q   <= '0;
            commit_tag_q   <= '0;
            commit_value_q <= '0;
        end else if (ena) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Tail never aliases a valid entry unless the buffer is full, and
            // allocation is blocked when full. The writes below therefore
            // never hit the same index.
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
            end
            if (do_wb) begin
                ready_q[in_cdb_tag] <= 1'b1;
            end
            if (do_commit) begin
                valid_q[head_q] <= 1'b0;
                commit_reg_q    <= rd_q[head_q];
                commit_tag_q    <= head_q;
                commit_value_q  <= value_q[head_q];
            end else begin
                commit_reg_q   <= '0;
                commit_tag_q   <= '0;
                commit_value_q <= '0;
            end
        end else begin
            // Holding still must not replay the last commit.
            commit_reg_q   <= '0;
            commit_tag_q   <= '0;
            commit_value_q <= '0;
        end
    end

    // NOTE: the rd/value payload storage has no reset. The valid/ready bits
    // gate every use of it, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            rd_q[tail_q] <= in_alloc_rd;
        end
        if (do_wb) begin
            value_q[in_cdb_tag] <= in_cdb_value;
        end
    end

    // Operand queries
    always_comb begin
        out_query_ready1 = valid_q[in_query_tag1] && ready_q[in_query_tag1];
        out_query_ready2 = valid_q[in_query_tag2] && ready_q[in_query_tag2];
        out_query_value1 = (in_query_tag1 == ZERO_ROB) ? '0 : value_q[in_query_tag1];
        out_query_value2 = (in_query_tag2 == ZERO_ROB) ? '0 : value_q[in_query_tag2];
`ifdef ROB_CDB_BYPASS_EN
        if (in_cdb_ena && (in_cdb_tag == in_query_tag1) && valid_q[in_query_tag1]) begin
            out_query_ready1 = 1'b1;
            out_query_value1 = in_cdb_value;
        end
        if (in_cdb_ena && (in_cdb_tag == in_query_tag2) && valid_q[in_query_tag2]) begin
            out_query_ready2 = 1'b1;
            out_query_value2 = in_cdb_value;
        end
`else
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Self-checking bench for reorder_buffer. A program-order queue models the
//   buffer, and tags are handed out round-robin over 1..15. Every cycle the
//   bench compares the combinational outputs (alloc tag, full, queries)
//   before the edge and the registered commit triple after the edge. Directed
//   scenarios also pin literal values. A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        in_alloc_ena;
    logic [4:0]  in_alloc_rd;
    logic [3:0]  out_alloc_tag;
    logic        out_full;
    logic        in_cdb_ena;
    logic [3:0]  in_cdb_tag;
    logic [31:0] in_cdb_value;
    logic [3:0]  in_query_tag1;
    logic [3:0]  in_query_tag2;
    logic        out_query_ready1;
    logic        out_query_ready2;
    logic [31:0] out_query_value1;
    logic [31:0] out_query_value2;
    logic [4:0]  out_commit_reg;
    logic [3:0]  out_commit_tag;
    logic [31:0] out_commit_value;

    reorder_buffer #(.ROB_SIZE(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .ena              (ena),
        .in_alloc_ena     (in_alloc_ena),
        .in_alloc_rd      (in_alloc_rd),
        .out_alloc_tag    (out_alloc_tag),
        .out_full         (out_full),
        .in_cdb_ena       (in_cdb_ena),
        .in_cdb_tag       (in_cdb_tag),
        .in_cdb_value     (in_cdb_value),
        .in_query_tag1    (in_query_tag1),
        .in_query_tag2    (in_query_tag2),
        .out_query_ready1 (out_query_ready1),
        .out_query_ready2 (out_query_ready2),
        .out_query_value1 (out_query_value1),
        .out_query_value2 (out_query_value2),
        .out_commit_reg   (out_commit_reg),
        .out_commit_tag   (out_commit_tag),
        .out_commit_value (out_commit_value)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        bit          rdy;
        logic [31:0] val;
    } ent_t;

    ent_t        q[$];        // in-flight instructions, oldest first
    logic [3:0]  m_next_tag;  // tag the next allocation receives
    logic [4:0]  e_reg;
    logic [3:0]  e_tag;
    logic [31:0] e_val;

    task automatic model_reset();
        q.delete();
        m_next_tag = 4'd1;
        e_reg = '0;
        e_tag = '0;
        e_val = '0;
    endtask

    task automatic model_query(input logic [3:0] t, output bit r, output logic [31:0] v);
        r = 1'b0;
        v = '0;
        if (t != 4'd0) begin
            foreach (q[i]) begin
                if (q[i].tag == t) begin
                    r = q[i].rdy;
                    v = q[i].val;
`ifdef ROB_CDB_BYPASS_EN
                    if (in_cdb_ena && in_cdb_tag == t) begin
                        r = 1'b1;
                        v = in_cdb_value;
                    end
`endif
                end
            end
        end
    endtask

    // One clock cycle. Inputs are already driven. The bench checks the
    // combinational outputs, advances the model, crosses the edge and then
    // checks the commit triple.
    task automatic step();
        bit          r;
        logic [31:0] v;
        bit          do_commit;
        bit          do_alloc;
        #1;
        check("alloc_tag", out_alloc_tag, m_next_tag);
        check("full", out_full, q.size() == 15);
        model_query(in_query_tag1, r, v);
        check("query_ready1", out_query_ready1, r);
        if (r || in_query_tag1 == 4'd0) check("query_value1", out_query_value1, v);
        model_query(in_query_tag2, r, v);
        check("query_ready2", out_query_ready2, r);
        if (r || in_query_tag2 == 4'd0) check("query_value2", out_query_value2, v);

        if (rst) begin
            model_reset();
        end else if (!ena) begin
            e_reg = '0;
            e_tag = '0;
            e_val = '0;
        end else begin
            do_commit = (q.size() > 0) && q[0].rdy;
            do_alloc  = in_alloc_ena && (q.size() < 15);
            if (do_commit) begin
                e_reg = q[0].rd;
                e_tag = q[0].tag;
                e_val = q[0].val;
            end else begin
                e_reg = '0;
                e_tag = '0;
                e_val = '0;
            end
            if (in_cdb_ena) begin
                foreach (q[i]) begin
                    if (q[i].tag == in_cdb_tag) begin
                        q[i].rdy = 1'b1;
                        q[i].val = in_cdb_value;
                    end
                end
            end
            if (do_commit) void'(q.pop_front());
            if (do_alloc) begin
                q.push_back('{tag: m_next_tag, rd: in_alloc_rd, rdy: 1'b0, val: 32'h0});
                m_next_tag = 4'((m_next_tag % 15) + 1);
            end
        end

        @(posedge clk);
        #1;
        check("commit_reg", out_commit_reg, e_reg);
        check("commit_tag", out_commit_tag, e_tag);
        check("commit_value", out_commit_value, e_val);
    endtask

    task automatic idle_inputs();
        rst           = 1'b0;
        ena           = 1'b1;
        in_alloc_ena  = 1'b0;
        in_alloc_rd   = '0;
        in_cdb_ena    = 1'b0;
        in_cdb_tag    = '0;
        in_cdb_value  = '0;
        in_query_tag1 = '0;
        in_query_tag2 = '0;
    endtask

    task automatic alloc(input logic [4:0] rd);
        idle_inputs();
        in_alloc_ena = 1'b1;
        in_alloc_rd  = rd;
        step();
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        idle_inputs();
        in_cdb_ena   = 1'b1;
        in_cdb_tag   = tag;
        in_cdb_value = val;
        step();
    endtask

    task automatic idle();
        idle_inputs();
        step();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset state, then idle for three cycles
        check("reset_alloc_tag", out_alloc_tag, 4'd1);
        check("reset_full", out_full, 1'b0);
        check("reset_commit_reg", out_commit_reg, 5'd0);
        repeat (3) idle();
        check("idle_alloc_tag", out_alloc_tag, 4'd1);

        // Basic allocate -> writeback -> commit
        alloc(5'd5);
        cdb(4'd1, 32'hDEADBEEF);
        idle();
        check("basic_commit_reg", out_commit_reg, 5'd5);
        check("basic_commit_tag", out_commit_tag, 4'd1);
        check("basic_commit_value", out_commit_value, 32'hDEADBEEF);
        idle();
        check("basic_commit_once", out_commit_reg, 5'd0);

        // Out-of-order completion still retires in program order
        do_reset();
        alloc(5'd3);
        alloc(5'd4);
        cdb(4'd2, 32'd7);
        idle();
        check("ooo_no_commit", out_commit_reg, 5'd0);
        cdb(4'd1, 32'd9);
        idle();
        check("ooo_first_reg", out_commit_reg, 5'd3);
        check("ooo_first_value", out_commit_value, 32'd9);
        idle();
        check("ooo_second_reg", out_commit_reg, 5'd4);
        check("ooo_second_value", out_commit_value, 32'd7);

        // Fill up, reject the overflow allocation, drain one, wrap to tag 1
        do_reset();
        for (int i = 1; i <= 15; i++) alloc(5'(i));
        check("fill_full", out_full, 1'b1);
        check("fill_tail_wrapped", out_alloc_tag, 4'd1);
        alloc(5'd31);
        check("overflow_tail_held", out_alloc_tag, 4'd1);
        cdb(4'd1, 32'h1111);
        idle();
        check("fill_commit_tag", out_commit_tag, 4'd1);
        check("fill_full_drops", out_full, 1'b0);
        check("fill_wrap_tag", out_alloc_tag, 4'd1);
        alloc(5'd20);

        // Query with and without a same-cycle broadcast
        do_reset();
        for (int i = 1; i <= 6; i++) alloc(5'(i));
        idle_inputs();
        in_query_tag1 = 4'd6;
        in_query_tag2 = 4'd0;
        #1;
        check("query_not_ready", out_query_ready1, 1'b0);
        check("query_tag0_ready", out_query_ready2, 1'b0);
        check("query_tag0_value", out_query_value2, 32'd0);
        in_cdb_ena   = 1'b1;
        in_cdb_tag   = 4'd6;
        in_cdb_value = 32'h55;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        check("query_bypass_ready", out_query_ready1, 1'b1);
        check("query_bypass_value", out_query_value1, 32'h55);
`else
        check("query_same_cycle_ready", out_query_ready1, 1'b0);
`endif
        step();
        idle_inputs();
        in_query_tag1 = 4'd6;
        #1;
        check("query_next_ready", out_query_ready1, 1'b1);
        check("query_next_value", out_query_value1, 32'h55);
        step();

        // Hold with a ready head, then release for a single commit
        do_reset();
        alloc(5'd9);
        cdb(4'd1, 32'hABCD);
        idle_inputs();
        ena = 1'b0;
        step();
        check("hold_no_commit1", out_commit_reg, 5'd0);
        step();
        check("hold_no_commit2", out_commit_reg, 5'd0);
        idle();
        check("hold_release_reg", out_commit_reg, 5'd9);
        check("hold_release_value", out_commit_value, 32'hABCD);
        idle();
        check("hold_single_commit", out_commit_reg, 5'd0);

        // Reset with live entries discards them, including same-cycle inputs
        for (int i = 0; i < 4; i++) alloc(5'(i + 10));
        cdb(4'd2, 32'h77);
        idle_inputs();
        rst          = 1'b1;
        in_alloc_ena = 1'b1;
        in_alloc_rd  = 5'd1;
        in_cdb_ena   = 1'b1;
        in_cdb_tag   = 4'd2;
        step();
        check("rst_alloc_tag", out_alloc_tag, 4'd1);
        check("rst_full", out_full, 1'b0);
        repeat (3) begin
            idle();
            check("rst_no_commit", out_commit_reg, 5'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            rst          = ($urandom_range(0, 199) == 0);
            ena          = ($urandom_range(0, 9) != 0);
            in_alloc_ena = ($urandom_range(0, 99) < 55);
            in_alloc_rd  = 5'($urandom);
            in_cdb_ena   = ($urandom_range(0, 99) < 60);
            if (q.size() > 0 && $urandom_range(0, 9) < 8)
                in_cdb_tag = q[$urandom_range(0, q.size() - 1)].tag;
            else
                in_cdb_tag = 4'($urandom);
            in_cdb_value = $urandom;
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                in_query_tag1 = q[$urandom_range(0, q.size() - 1)].tag;
            else
                in_query_tag1 = 4'($urandom);
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                in_query_tag2 = in_cdb_tag;
            else
                in_query_tag2 = 4'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
